// File: rtl/regfile_wordline_ctrl.sv
// rtl/regfile_wordline_ctrl.sv - word-line drive, busy scoreboard and hazard stall for the bit-cell register file
module regfile_wordline_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   src1_addr,
  input  logic [ADDR_W-1:0]   src2_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic                dst_wr,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic [NUM_REGS-1:0] rd_en1,
  output logic [NUM_REGS-1:0] rd_en2,
  output logic [NUM_REGS-1:0] wr_en,
  output logic                rd_valid,
  output logic                bypass1,
  output logic                bypass2,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [ADDR_W-1:0]   r_src1_q;
  logic [ADDR_W-1:0]   r_src2_q;
  logic                r_rd_valid;

  logic                w_haz_src1;
  logic                w_haz_src2;
  logic                w_haz_dst;
  logic                w_accept;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Register 0 is hardwired zero, so its row is never driven.
  function automatic logic [NUM_REGS-1:0] f_onehot(input logic [ADDR_W-1:0] a);
    f_onehot = '0;
    if (a != '0) f_onehot[a] = 1'b1;
  endfunction

  // A writeback landing this cycle resolves the hazard on its register.
  assign w_haz_src1 = (src1_addr != '0) && r_busy[src1_addr] && !(wb_valid && wb_addr == src1_addr);
  assign w_haz_src2 = (src2_addr != '0) && r_busy[src2_addr] && !(wb_valid && wb_addr == src2_addr);
  assign w_haz_dst  = dst_wr && (dst_addr != '0) && r_busy[dst_addr] && !(wb_valid && wb_addr == dst_addr);

  assign req_ready = !w_haz_src1 && !w_haz_src2 && !w_haz_dst;
  assign w_accept  = req_valid && req_ready;

  assign wr_en    = (rst_n && wb_valid) ? f_onehot(wb_addr) : '0;
  assign rd_en1   = r_rd_valid ? f_onehot(r_src1_q) : '0;
  assign rd_en2   = r_rd_valid ? f_onehot(r_src2_q) : '0;
  assign rd_valid = r_rd_valid;
  assign bypass1  = r_rd_valid && wb_valid && (wb_addr == r_src1_q) && (r_src1_q != '0);
  assign bypass2  = r_rd_valid && wb_valid && (wb_addr == r_src2_q) && (r_src2_q != '0);
  assign busy     = r_busy;

  // Clear first, then set, so a new writer of the retiring register keeps it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) w_busy_nxt[wb_addr] = 1'b0;
    if (w_accept && dst_wr && (dst_addr != '0)) w_busy_nxt[dst_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_src1_q   <= '0;
      r_src2_q   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_rd_valid <= w_accept;
      if (w_accept) begin
        r_src1_q <= src1_addr;
        r_src2_q <= src2_addr;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wordline_ctrl.sv
// tb/tb_regfile_wordline_ctrl.sv - scoreboard bench for regfile_wordline_ctrl
module tb_regfile_wordline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  src1_addr = '0;
  logic [3:0]  src2_addr = '0;
  logic [3:0]  dst_addr = '0;
  logic        dst_wr = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [15:0] rd_en1, rd_en2, wr_en, busy;
  logic        rd_valid, bypass1, bypass2;

  regfile_wordline_ctrl #(.NUM_REGS(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .src1_addr(src1_addr), .src2_addr(src2_addr), .dst_addr(dst_addr), .dst_wr(dst_wr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .rd_en1(rd_en1), .rd_en2(rd_en2), .wr_en(wr_en),
    .rd_valid(rd_valid), .bypass1(bypass1), .bypass2(bypass2), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int s1; int s2; int cyc;} rd_t;
  rd_t q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 0;

  // Reference state: which registers have a write outstanding.
  bit busy_m[16];
  bit        exp_ready = 1;
  logic [15:0] exp_wr = '0;
  logic [15:0] exp_busy = '0;
  bit p_wv = 0, p_acc = 0, p_dw = 0;
  int p_wa = 0, p_d = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] row(input int a);
    return (a == 0) ? 16'h0 : 16'(1 << a);
  endfunction

  function automatic bit hz(input int s, input bit wv, input int wa);
    return (s != 0) && busy_m[s] && !(wv && wa == s);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) busy_m[i] = 0;
    q.delete();
    p_wv = 0; p_acc = 0; p_dw = 0; p_wa = 0; p_d = 0;
    exp_ready = 1; exp_wr = '0; exp_busy = '0;
  endtask

  task automatic step(input bit rv, input int s1, input int s2, input int d, input bit dw,
                      input bit wv, input int wa);
    bit acc;
    @(posedge clk); #1;
    if (p_wv) busy_m[p_wa] = 0;
    if (p_acc && p_dw && p_d != 0) busy_m[p_d] = 1;
    req_valid = rv; src1_addr = 4'(s1); src2_addr = 4'(s2); dst_addr = 4'(d); dst_wr = dw;
    wb_valid = wv; wb_addr = 4'(wa);
    exp_ready = !hz(s1, wv, wa) && !hz(s2, wv, wa) && !(dw && hz(d, wv, wa));
    acc = rv && exp_ready;
    if (acc) q.push_back('{s1: s1, s2: s2, cyc: cyc + 1});
    exp_wr = wv ? row(wa) : 16'h0;
    for (int i = 0; i < 16; i++) exp_busy[i] = busy_m[i];
    p_wv = wv; p_wa = wa; p_acc = acc; p_dw = dw; p_d = d;
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      bit ev;
      chk("req_ready", req_ready, exp_ready);
      chk("wr_en", wr_en, exp_wr);
      chk("busy", busy, exp_busy);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL rd_missing: read issued for cyc %0d never seen", q[0].cyc);
        void'(q.pop_front());
      end
      ev = (q.size() > 0) && (q[0].cyc == cyc);
      chk("rd_valid", rd_valid, ev);
      if (ev) begin
        rd_t e;
        e = q.pop_front();
        chk("rd_en1", rd_en1, row(e.s1));
        chk("rd_en2", rd_en2, row(e.s2));
        chk("bypass1", bypass1, wb_valid && int'(wb_addr) == e.s1 && e.s1 != 0);
        chk("bypass2", bypass2, wb_valid && int'(wb_addr) == e.s2 && e.s2 != 0);
      end else begin
        chk("rd_en1_idle", rd_en1, 0);
        chk("rd_en2_idle", rd_en2, 0);
        chk("bypass_idle", {bypass1, bypass2}, 0);
      end
    end
  end

  initial begin
    model_clear();
    wb_valid = 1; wb_addr = 4'd5;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    wb_valid = 0; wb_addr = 0;
    rst_n = 1;
    mon_en = 1;

    // Reset while a read is on the bitlines and reg 4 is busy.
    step(1, 2, 6, 4, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_busy", busy, 16'h0010);
    chk("pre_rst_rd_valid", rd_valid, 1);
    rst_n = 0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_rd_valid", rd_valid, 0);
    chk("async_rd_en", {rd_en1, rd_en2}, 0);
    req_valid = 0; wb_valid = 0; dst_wr = 0;
    model_clear();
    @(posedge clk); #2;
    rst_n = 1;

    // Plain read of 3 and 5.
    step(1, 3, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // RAW on 7 released by writeback of 7.
    step(1, 1, 2, 7, 1, 0, 0);
    step(1, 7, 0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0, 1, 7);
    step(0, 0, 0, 0, 0, 0, 0);
    // Bypass on operand 2.
    step(1, 0, 9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 9);
    // Register 0.
    step(1, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    // Retire and re-claim reg 4 in the same cycle.
    step(1, 0, 0, 4, 1, 0, 0);
    step(1, 0, 0, 4, 1, 1, 4);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 4);

    for (int i = 0; i < 3000; i++) begin
      int wa;
      bit wv;
      wv = ($urandom % 3) == 0;
      wa = $urandom % 16;
      if (wv && ($urandom % 2)) begin
        for (int k = 0; k < 16; k++) if (busy_m[(wa + k) % 16]) begin wa = (wa + k) % 16; break; end
      end
      step($urandom % 4 != 0, $urandom % 16, $urandom % 16, $urandom % 16, $urandom % 2, wv, wa);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL rd_leftover: %0d reads pending, required 0", q.size());
    end
    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
